// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// master drives enable and ratio load; slave returns clock, tick and ratio state.
interface clk_div_prog_if #(
  parameter int DIV_W = 16
);
  logic             EN;
  logic [DIV_W-1:0] DIV_IN;
  logic             DIV_LD;
  logic             DIV_PEND;
  logic [DIV_W-1:0] DIV_CUR;
  logic             CLKOUT;
  logic             TICK;

  modport master (
    output EN, DIV_IN, DIV_LD,
    input  DIV_PEND, DIV_CUR, CLKOUT, TICK
  );

  modport slave (
    input  EN, DIV_IN, DIV_LD,
    output DIV_PEND, DIV_CUR, CLKOUT, TICK
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider.
// New ratios take effect only at a period boundary, so CLKOUT never glitches.
module clk_div_prog #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  clk_div_prog_if.slave bus
);
  localparam logic [DIV_W-1:0] DEF = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cur;
  logic [DIV_W-1:0] pend_v;
  logic             pend;
  logic             clkout_q;
  logic             tick_q;

  logic             boundary;
  logic             apply;
  logic [DIV_W-1:0] n_eff;
  logic [DIV_W-1:0] h_eff;
  logic [DIV_W-1:0] cnt_nx;
  logic [DIV_W-1:0] ld_v;

  // Next-count and the ratio that governs the upcoming cycle
  always_comb begin
    boundary = (cnt == cur - ONE);
    apply    = bus.EN && boundary && pend;
    n_eff    = apply ? pend_v : cur;
    h_eff    = n_eff >> 1;
    cnt_nx   = boundary ? '0 : cnt + ONE;
    ld_v     = (bus.DIV_IN < TWO) ? TWO : bus.DIV_IN;
  end

  // Counter, active ratio and registered outputs; frozen while EN is low
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt      <= DEF - ONE;
      cur      <= DEF;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
    end else if (bus.EN) begin
      cnt      <= cnt_nx;
      cur      <= n_eff;
      clkout_q <= (cnt_nx < h_eff);
      tick_q   <= (cnt_nx == '0);
    end else begin
      tick_q   <= 1'b0;
    end
  end

  // Pending ratio: a load on the apply edge queues behind the applied one
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_v <= DEF;
      pend   <= 1'b0;
    end else if (bus.DIV_LD) begin
      pend_v <= ld_v;
      pend   <= 1'b1;
    end else if (apply) begin
      pend   <= 1'b0;
    end
  end

  assign bus.DIV_PEND = pend;
  assign bus.DIV_CUR  = cur;
  assign bus.CLKOUT   = clkout_q;
  assign bus.TICK     = tick_q;
endmodule
